// File: rtl/riscy_obi_mem_responder.sv
// Memory-side responder for the RI5CY req/gnt/rvalid data port.
// Grants core requests (optional stall, outstanding limit), applies
// byte-enabled stores, returns in-order responses after a fixed latency,
// and reports accepted stores / out-of-range accesses to the bench monitor.
module riscy_obi_mem_responder #(
  parameter int unsigned DEPTH_WORDS     = 1024,
  parameter int unsigned GNT_STALL       = 0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        ld_we_i,
  input  logic [31:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        store_valid_o,
  output logic [31:0] store_addr_o,
  output logic [31:0] store_data_o,
  output logic        oob_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = (GNT_STALL > 2) ? $clog2(GNT_STALL) : 1;
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, STALL, GRANT} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [OW-1:0]     outst_q;
  logic              blk, gnt_raw, acc;
  logic [AW-1:0]     idx, ld_idx;
  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_word, merged;
  logic [RESP_LATENCY-1:0]       vld_pipe;
  logic [RESP_LATENCY-1:0][31:0] dat_pipe;

  logic unused_bits;
  assign unused_bits = ^{addr_i[1:0], ld_addr_i[1:0], ld_addr_i[31:AW+2]};

  assign idx     = addr_i[AW+1:2];
  assign ld_idx  = ld_addr_i[AW+1:2];
  assign rd_word = mem[idx];

  // Merge enabled store byte lanes over the current memory word
  always_comb begin
    merged = rd_word;
    for (int k = 0; k < 4; k++)
      if (be_i[k]) merged[8*k +: 8] = wdata_i[8*k +: 8];
  end

  // Backdoor write wins the cycle; at the outstanding limit a response
  // leaving this cycle frees the slot for a new accept.
  assign blk = ld_we_i || (outst_q == OW'(MAX_OUTSTANDING) && !rvalid_o);

  // Grant FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Grant FSM next state / grant. The IDLE cycle counts as the first of the
  // GNT_STALL idle cycles, so STALL covers the remaining GNT_STALL-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_raw = 1'b0;
    case (state_q)
      IDLE: if (req_i && !blk) begin
        if (GNT_STALL == 0) gnt_raw = 1'b1;
        else if (GNT_STALL == 1) state_d = GRANT;
        else begin
          state_d = STALL;
          cnt_d   = CW'(GNT_STALL - 2);
        end
      end
      STALL: begin
        if (!req_i)            state_d = IDLE;
        else if (cnt_q == '0)  state_d = GRANT;
        else                   cnt_d   = cnt_q - CW'(1);
      end
      GRANT: begin
        gnt_raw = req_i && !blk;
        if (gnt_raw) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt_o = gnt_raw && rst_ni;
  assign acc   = gnt_o;

  // Outstanding count: +1 per accept, -1 per response
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) outst_q <= '0;
    else if (acc && !rvalid_o) outst_q <= outst_q + OW'(1);
    else if (!acc && rvalid_o) outst_q <= outst_q - OW'(1);
  end

  // Backing array, not reset; backdoor and core writes never share a cycle
  always_ff @(posedge clk_i) begin
    if (ld_we_i)          mem[ld_idx] <= ld_wdata_i;
    else if (acc && we_i) mem[idx]    <= merged;
  end

  // Response pipeline entry; store responses carry zero data
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_pipe[0] <= 1'b0;
      dat_pipe[0] <= '0;
    end else begin
      vld_pipe[0] <= acc;
      dat_pipe[0] <= (acc && !we_i) ? rd_word : '0;
    end
  end

  for (genvar g = 1; g < RESP_LATENCY; g++) begin : g_pipe
    // Shift response stage g-1 into stage g
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_pipe[g] <= 1'b0;
        dat_pipe[g] <= '0;
      end else begin
        vld_pipe[g] <= vld_pipe[g-1];
        dat_pipe[g] <= dat_pipe[g-1];
      end
    end
  end

  assign rvalid_o = vld_pipe[RESP_LATENCY-1];
  assign rdata_o  = dat_pipe[RESP_LATENCY-1];

  // Store capture and out-of-range flag, one cycle after accept
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      store_valid_o <= 1'b0;
      store_addr_o  <= '0;
      store_data_o  <= '0;
      oob_o         <= 1'b0;
    end else begin
      store_valid_o <= acc && we_i;
      oob_o         <= acc && ((addr_i >> (AW + 2)) != '0);
      if (acc && we_i) begin
        store_addr_o <= addr_i;
        store_data_o <= merged;
      end
    end
  end

endmodule

// File: tb/tb_riscy_obi_mem_responder.sv
// Directed bench: three responder configurations share stimulus buses,
// each with its own request line.
//   u_a: no stall, latency 3, 2 outstanding (load/store/collision/oob/reset)
//   u_b: 2-cycle grant stall, latency 1, 1 outstanding
//   u_c: no stall, latency 4, 2 outstanding (backpressure)
module tb_riscy_obi_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_a, req_b, req_c;
  logic [31:0] addr, wdata, ld_addr, ld_wdata;
  logic        we, ld_we;
  logic [3:0]  be;

  logic        gnt_a, rvalid_a, sv_a, oob_a;
  logic [31:0] rdata_a, sa_a, sd_a;
  logic        gnt_b, rvalid_b, sv_b, oob_b;
  logic [31:0] rdata_b, sa_b, sd_b;
  logic        gnt_c, rvalid_c, sv_c, oob_c;
  logic [31:0] rdata_c, sa_c, sd_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscy_obi_mem_responder #(.DEPTH_WORDS(1024), .GNT_STALL(0), .RESP_LATENCY(3), .MAX_OUTSTANDING(2)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
    .ld_wdata_i(ld_wdata), .store_valid_o(sv_a), .store_addr_o(sa_a), .store_data_o(sd_a), .oob_o(oob_a));

  riscy_obi_mem_responder #(.DEPTH_WORDS(1024), .GNT_STALL(2), .RESP_LATENCY(1), .MAX_OUTSTANDING(1)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
    .ld_wdata_i(ld_wdata), .store_valid_o(sv_b), .store_addr_o(sa_b), .store_data_o(sd_b), .oob_o(oob_b));

  riscy_obi_mem_responder #(.DEPTH_WORDS(1024), .GNT_STALL(0), .RESP_LATENCY(4), .MAX_OUTSTANDING(2)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_c), .gnt_o(gnt_c), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .rvalid_o(rvalid_c), .rdata_o(rdata_c), .ld_we_i(ld_we), .ld_addr_i(ld_addr),
    .ld_wdata_i(ld_wdata), .store_valid_o(sv_c), .store_addr_o(sa_c), .store_data_o(sd_c), .oob_o(oob_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [31:0] c_addr [4];
  logic [31:0] c_data [4];
  logic        exp_g  [6];
  logic        exp_rv [11];
  int          n, r;

  initial begin
    c_addr = '{32'h100, 32'h40, 32'h8, 32'hC};
    c_data = '{32'hDEADBEEF, 32'h11223344, 32'hCAFEF00D, 32'h0BADF00D};
    exp_g  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_rv = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0; req_a = 0; req_b = 0; req_c = 0;
    addr = '0; we = 0; be = 4'hF; wdata = '0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    tick(); tick();
    smp();
    chk("rst_gnt", gnt_a, 0);
    chk("rst_rvalid", rvalid_a, 0);
    chk("rst_rdata", rdata_a, 0);
    chk("rst_store_valid", sv_a, 0);
    chk("rst_oob", oob_a, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // backdoor preload of all instances
    ld_we = 1;
    for (int i = 0; i < 4; i++) begin
      ld_addr = c_addr[i]; ld_wdata = c_data[i];
      tick();
    end
    ld_we = 0;

    // load 0x100: same-cycle grant, data three cycles later
    req_a = 1; we = 0; addr = 32'h100;
    smp(); chk("ld_gnt", gnt_a, 1);
    tick(); req_a = 0;
    smp(); chk("ld_rv_c1", rvalid_a, 0);
    tick();
    smp(); chk("ld_rv_c2", rvalid_a, 0);
    tick();
    smp(); chk("ld_rv_c3", rvalid_a, 1); chk("ld_rdata", rdata_a, 32'hDEADBEEF);
    tick();
    smp(); chk("ld_rv_after", rvalid_a, 0);
    tick();

    // byte store then back-to-back load of the same word
    req_a = 1; we = 1; addr = 32'h40; be = 4'b0010; wdata = 32'h0000AA00;
    smp(); chk("st_gnt", gnt_a, 1);
    tick();
    we = 0; be = 4'hF; wdata = '0;
    smp();
    chk("st_valid", sv_a, 1);
    chk("st_addr", sa_a, 32'h40);
    chk("st_data", sd_a, 32'h1122AA44);
    chk("st_ld_gnt", gnt_a, 1);
    tick(); req_a = 0;
    smp(); chk("st_valid_pulse", sv_a, 0);
    tick();
    smp(); chk("st_rsp_rv", rvalid_a, 1); chk("st_rsp_rdata", rdata_a, 0);
    tick();
    smp(); chk("st_ld_rv", rvalid_a, 1); chk("st_ld_rdata", rdata_a, 32'h1122AA44);
    tick();
    smp(); chk("st_ld_rv_after", rvalid_a, 0);
    tick();

    // collision with backdoor, then out-of-range load wrapping to word 2
    req_a = 1; addr = 32'h1008; ld_we = 1; ld_addr = 32'h200; ld_wdata = 32'h55;
    smp(); chk("coll_gnt", gnt_a, 0);
    tick(); ld_we = 0;
    smp(); chk("oob_gnt", gnt_a, 1);
    tick(); req_a = 0;
    smp(); chk("oob_pulse", oob_a, 1); chk("oob_rv0", rvalid_a, 0);
    tick();
    smp(); chk("oob_clear", oob_a, 0);
    tick();
    smp(); chk("oob_rv", rvalid_a, 1); chk("oob_rdata", rdata_a, 32'hCAFEF00D);
    tick();

    // grant stall of 2: grant on the third cycle of a held request
    req_b = 1; addr = 32'h100;
    smp(); chk("stall_gnt_c1", gnt_b, 0);
    tick();
    smp(); chk("stall_gnt_c2", gnt_b, 0);
    tick();
    smp(); chk("stall_gnt_c3", gnt_b, 1);
    tick(); req_b = 0;
    smp(); chk("stall_rv", rvalid_b, 1); chk("stall_rdata", rdata_b, 32'hDEADBEEF); chk("stall_gnt_c4", gnt_b, 0);
    tick();
    smp(); chk("stall_one_accept", rvalid_b, 0);
    tick();

    // backpressure: 4 held loads, limit 2 outstanding, latency 4
    n = 0; r = 0; req_c = 1;
    for (int k = 0; k < 11; k++) begin
      if (k == 6) req_c = 0;
      if (n < 4) addr = c_addr[n];
      smp();
      chk($sformatf("bp_gnt_%0d", k), gnt_c, (k < 6) ? exp_g[k] : 1'b0);
      chk($sformatf("bp_rv_%0d", k), rvalid_c, exp_rv[k]);
      if (exp_rv[k]) begin
        chk($sformatf("bp_rdata_%0d", r), rdata_c, c_data[r]);
        r++;
      end
      if (k < 6 && exp_g[k]) n++;
      tick();
    end

    // reset with one load pending drops the response
    req_a = 1; addr = 32'h100;
    smp(); chk("rst_ld_gnt", gnt_a, 1);
    tick(); req_a = 0;
    tick();
    rst_n = 1'b0; req_a = 1;
    smp();
    chk("midrst_gnt", gnt_a, 0);
    chk("midrst_rvalid", rvalid_a, 0);
    chk("midrst_rdata", rdata_a, 0);
    tick();
    rst_n = 1'b1; req_a = 0;
    for (int k = 0; k < 4; k++) begin
      smp(); chk($sformatf("postrst_rv_%0d", k), rvalid_a, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
